// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, read-FSM state encoding and counter helper
package sram_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sram_responder_array.sv
// sram_responder_array: byte-writable MEM_WORDS x 16 array, one write port, one async read port
module sram_responder_array
  import sram_pkg::*;
#(
  parameter int MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [IW-1:0] widx, ridx;
  // out-of-range addresses alias onto the array rather than faulting
  assign widx = IW'(waddr % ADDR_W'(MEM_WORDS));
  assign ridx = IW'(raddr % ADDR_W'(MEM_WORDS));
  assign rdata = mem[ridx];
  // contents survive reset, so the array has no reset term
  always_ff @(posedge clk) begin
    if (we[1]) mem[widx][15:8] <= wdata[15:8];
    if (we[0]) mem[widx][7:0] <= wdata[7:0];
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: async-SRAM bus model with programmable read latency and byte lanes
module sram_responder
  import sram_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic              dq_oe,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  state_t state, state_n;
  logic [LAT_W-1:0] lat_cnt, lat_n;
  logic [ADDR_W-1:0] addr_reg, addr_n;
  logic [DATA_W-1:0] data_reg, data_n, rd_data;
  logic req, wr, rd_inc, drv_ub, drv_lb;
  assign req = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign wr = !SRAM_CE_N && !SRAM_WE_N;
  sram_responder_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk   (clk),
    .we    ({wr && !SRAM_UB_N, wr && !SRAM_LB_N}),
    .waddr (SRAM_ADDR),
    .wdata (SRAM_DQ),
    .raddr (addr_reg),
    .rdata (rd_data)
  );
  // drive is gated by the live request so a write or deselect releases the bus at once
  assign drv_ub = (state == DRIVE) && req && !SRAM_UB_N;
  assign drv_lb = (state == DRIVE) && req && !SRAM_LB_N;
  assign dq_oe = drv_ub || drv_lb;
  assign SRAM_DQ[15:8] = drv_ub ? data_reg[15:8] : 8'hzz;
  assign SRAM_DQ[7:0] = drv_lb ? data_reg[7:0] : 8'hzz;
  // read FSM: drop on lost request, restart on address change, else count down then drive
  always_comb begin
    state_n = state;
    lat_n = lat_cnt;
    addr_n = addr_reg;
    data_n = data_reg;
    rd_inc = 1'b0;
    if (state != IDLE && !req) state_n = IDLE;
    else if (req && (state == IDLE || SRAM_ADDR != addr_reg)) begin
      state_n = WAIT;
      addr_n = SRAM_ADDR;
      lat_n = LAT_W'(READ_LAT - 1);
    end else if (state == WAIT && lat_cnt == '0) begin
      state_n = DRIVE;
      data_n = rd_data;
      rd_inc = 1'b1;
    end else if (state == WAIT) lat_n = lat_cnt - 1'b1;
    else if (state == DRIVE) data_n = rd_data;
  end
  // FSM and read datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      state <= state_n;
      lat_cnt <= lat_n;
      addr_reg <= addr_n;
      data_reg <= data_n;
    end
  end
  // saturating completed-read and write-cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_inc) rd_count <= sat_inc(rd_count);
      if (wr) wr_count <= sat_inc(wr_count);
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized self-checking bench against a word-array reference model
module tb_sram_responder;
  localparam int MW = 2048;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst;
  logic [17:0] addr;
  logic we_n, ce_n, oe_n, ub_n, lb_n;
  logic tb_drv;
  logic [15:0] tb_dq;
  wire [15:0] dq;
  logic dq_oe;
  logic [15:0] rd_count, wr_count;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem_m [MW];
  logic [15:0] rd_m, wr_m;
  logic [17:0] pool [16];

  assign dq = tb_drv ? tb_dq : 16'hzzzz;
  always #5 clk = ~clk;

  sram_responder #(.MEM_WORDS(MW), .READ_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .SRAM_DQ   (dq),
    .SRAM_ADDR (addr),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .dq_oe     (dq_oe),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ce_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
    ub_n = 1'b0;
    lb_n = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    addr = a;
    tb_dq = d;
    tb_drv = 1'b1;
    ce_n = 1'b0;
    we_n = 1'b0;
    oe_n = 1'b1;
    ub_n = ub;
    lb_n = lb;
    #1;
    checks++;
    if (dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_nodrive addr=%h dq_oe=%b want 0", a, dq_oe);
    end
    cyc();
    if (!ub) mem_m[a % MW][15:8] = d[15:8];
    if (!lb) mem_m[a % MW][7:0] = d[7:0];
    if (wr_m != 16'hFFFF) wr_m++;
    idle_bus();
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (rd_count !== rd_m || wr_count !== wr_m) begin
      errors++;
      $display("FAIL %s_counts rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rd_count, wr_count, rd_m, wr_m);
    end
  endtask

  // hold a read for 'hold' edges; at edge 'sw' the address switches to a2 (sw<0: never)
  task automatic do_read(input logic [17:0] a, input logic ub, input logic lb, input int hold,
                         input logic [17:0] a2, input int sw, input string tag);
    int cnt;
    logic exp_oe;
    logic [15:0] mask, exp;
    cnt = 0;
    addr = a;
    ce_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
    ub_n = ub;
    lb_n = lb;
    tb_drv = 1'b0;
    mask = {{8{!ub}}, {8{!lb}}};
    for (int k = 1; k <= hold; k++) begin
      if (k == sw) begin
        addr = a2;
        cnt = 0;
      end
      cyc();
      cnt++;
      if (cnt == LAT + 1 && rd_m != 16'hFFFF) rd_m++;
      exp_oe = (cnt > LAT) && (!ub || !lb);
      checks++;
      if (dq_oe !== exp_oe) begin
        errors++;
        $display("FAIL %s_oe edge=%0d dq_oe=%b want %b", tag, k, dq_oe, exp_oe);
      end
      if (exp_oe) begin
        exp = mem_m[addr % MW];
        checks++;
        if ((dq & mask) !== (exp & mask)) begin
          errors++;
          $display("FAIL %s_data edge=%0d addr=%h dq=%h want %h mask %h", tag, k, addr, dq, exp, mask);
        end
      end
    end
    idle_bus();
    #1;
    checks++;
    if (dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_release dq_oe=%b want 0", tag, dq_oe);
    end
    cyc();
    check_counts(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    addr = '0;
    tb_dq = '0;
    rd_m = '0;
    wr_m = '0;
    cyc();
    cyc();
    checks++;
    if (dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe dq_oe=%b want 0", dq_oe);
    end
    check_counts("reset");
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    do_write(18'd5, 16'h1234, 1'b0, 1'b0);
    do_read(18'd5, 1'b0, 1'b0, LAT + 3, 18'd0, -1, "basic");
    checks++;
    if (rd_count !== 16'd1 || wr_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_abs rd=%0d wr=%0d want 1 1", rd_count, wr_count);
    end
  endtask

  task automatic test_byte_enable();
    do_write(18'd5, 16'hAB00, 1'b0, 1'b1);
    checks++;
    if (mem_m[5] !== 16'hAB34) begin
      errors++;
      $display("FAIL be_model got %h want ab34", mem_m[5]);
    end
    do_read(18'd5, 1'b0, 1'b0, LAT + 2, 18'd0, -1, "be_both");
    do_read(18'd5, 1'b1, 1'b0, LAT + 2, 18'd0, -1, "be_low");
    do_read(18'd5, 1'b0, 1'b1, LAT + 2, 18'd0, -1, "be_high");
  endtask

  task automatic test_restart();
    do_write(18'd7, 16'h7777, 1'b0, 1'b0);
    do_write(18'd9, 16'h9999, 1'b0, 1'b0);
    do_read(18'd7, 1'b0, 1'b0, LAT + 5, 18'd9, 2, "restart_wait");
    do_read(18'd7, 1'b0, 1'b0, LAT + 7, 18'd9, LAT + 3, "restart_drive");
  endtask

  task automatic test_write_release();
    do_write(18'd11, 16'h5A5A, 1'b0, 1'b0);
    addr = 18'd11;
    ce_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
    for (int k = 0; k <= LAT; k++) cyc();
    if (rd_m != 16'hFFFF) rd_m++;
    checks++;
    if (dq_oe !== 1'b1 || dq !== 16'h5A5A) begin
      errors++;
      $display("FAIL wrel_drive dq_oe=%b dq=%h want 1 5a5a", dq_oe, dq);
    end
    we_n = 1'b0;
    tb_dq = 16'hC3C3;
    tb_drv = 1'b1;
    #1;
    checks++;
    if (dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL wrel_release dq_oe=%b want 0", dq_oe);
    end
    cyc();
    mem_m[11] = 16'hC3C3;
    if (wr_m != 16'hFFFF) wr_m++;
    idle_bus();
    do_read(18'd11, 1'b0, 1'b0, LAT + 2, 18'd0, -1, "wrel_readback");
  endtask

  task automatic test_wrap();
    do_write(18'd2051, 16'hBEEF, 1'b0, 1'b0);
    do_read(18'd3, 1'b0, 1'b0, LAT + 2, 18'd0, -1, "wrap");
    checks++;
    if (mem_m[3] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wrap_model got %h want beef", mem_m[3]);
    end
  endtask

  task automatic test_random();
    int j;
    logic [17:0] a2;
    for (int i = 0; i < 16; i++) begin
      pool[i] = 18'($urandom);
      do_write(pool[i], 16'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      j = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) do_write(pool[j], 16'($urandom), 1'($urandom), 1'($urandom));
      else begin
        a2 = pool[$urandom_range(0, 15)];
        if (a2 == pool[j]) a2 = pool[j] ^ 18'h00800;
        if (a2 % MW != pool[j] % MW) a2 = pool[j] ^ 18'h00800;
        do_read(pool[j], 1'($urandom), 1'($urandom), LAT + 1 + $urandom_range(0, 4),
                a2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT + 2) : -1, "rand");
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(18'd20, 16'h1357, 1'b0, 1'b0);
    addr = 18'd20;
    ce_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dq_oe !== 1'b0 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_wait dq_oe=%b rd=%0d wr=%0d want 0 0 0", dq_oe, rd_count, wr_count);
    end
    idle_bus();
    cyc();
    rst = 1'b0;
    rd_m = '0;
    wr_m = '0;
    addr = 18'd20;
    ce_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
    for (int k = 0; k <= LAT; k++) cyc();
    checks++;
    if (dq_oe !== 1'b1 || rd_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_pre_drive dq_oe=%b rd=%0d want 1 1", dq_oe, rd_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dq_oe !== 1'b0 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_drive dq_oe=%b rd=%0d wr=%0d want 0 0 0", dq_oe, rd_count, wr_count);
    end
    idle_bus();
    cyc();
    rst = 1'b0;
    do_read(18'd20, 1'b0, 1'b0, LAT + 2, 18'd0, -1, "rst_retain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_restart();
    test_write_release();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter MEM_WORDS, default 2048, meaning backing array depth in 16-bit words; index = SRAM_ADDR mod MEM_WORDS.
REQ-002 Parameter READ_LAT, default 2, meaning cycles from read-request sample to DQ valid; legal range 1..15.
REQ-003 Ports: clk  input  1  single clock, all state on rising edge.
REQ-004 Ports: rst  input  1  asynchronous, active-high reset.
REQ-005 Ports: SRAM_DQ  inout  16  bidirectional data; driven only while reading, otherwise high-Z.
REQ-006 Ports: SRAM_ADDR  input  18  word address.
REQ-007 Ports: SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  input  1 each  active-low write enable, chip enable, output enable, upper-byte enable, lower-byte enable.
REQ-008 Ports: dq_oe  output  1  high while the block drives any DQ byte.
REQ-009 Ports: rd_count, wr_count  output  16 each  completed-read and write-cycle counters.

Function
REQ-010 Write cycle: on a rising edge sampling CE_N=0 and WE_N=0, the block SHALL write DQ[15:8] if UB_N=0 and DQ[7:0] if LB_N=0 into the indexed word, and SHALL not drive DQ.
REQ-011 States: IDLE, WAIT, DRIVE; a read request is CE_N=0, WE_N=1, OE_N=0.
REQ-012 IDLE -> WAIT on a sampled read request; the block latches addr_reg and loads lat_cnt with READ_LAT-1.
REQ-013 WAIT: lat_cnt decrements each cycle; at lat_cnt=0, -> DRIVE and data_reg loads mem[addr_reg]; for READ_LAT=1, DRIVE begins the cycle after the request.
REQ-014 WAIT or DRIVE with a request whose SRAM_ADDR differs from addr_reg SHALL re-latch the address, reload lat_cnt, and go to WAIT (restart).
REQ-015 WAIT or DRIVE with no request (CE_N=1, OE_N=1, or WE_N=0) SHALL go to IDLE; a write in that cycle is still performed per REQ-010.
REQ-016 DRIVE: data_reg SHALL reload mem[addr_reg] every cycle, tracking the array.
REQ-017 Output drive SHALL be combinational: upper byte driven iff state=DRIVE, request true this cycle, and UB_N=0; lower byte likewise with LB_N; undriven bytes high-Z; dq_oe = OR of both.
REQ-018 The block SHALL never drive DQ in any cycle where WE_N=0 or CE_N=1 (no bus contention).
REQ-019 rd_count SHALL increment once per WAIT->DRIVE transition; wr_count once per write-cycle edge; both saturate at 16'hFFFF.
REQ-020 Address wrap: an address >= MEM_WORDS SHALL alias to SRAM_ADDR mod MEM_WORDS with no error.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, lat_cnt 0, addr_reg 0, data_reg 0, rd_count 0, wr_count 0, dq_oe 0, and DQ high-Z, independent of clk.
REQ-022 Array contents SHALL NOT be cleared by reset; a read in progress when reset asserts SHALL be abandoned, with no rd_count increment.
REQ-023 After rst deasserts, the first sampled request SHALL start a full READ_LAT wait.

Structure
REQ-024 Shared package sram_pkg SHALL hold ADDR_W=18, DATA_W=16, and the IDLE/WAIT/DRIVE state encoding, used also by the memory-stage controller.
REQ-025 One sub-module sram_responder_array SHALL implement the byte-writable MEM_WORDS x 16 array with one write port and one asynchronous read port.

Verification
REQ-026 Write 0x1234 to addr 5 (UB_N=LB_N=0), then read addr 5 with READ_LAT=2 -> dq_oe rises on the 2nd edge after the request, DQ=0x1234, rd_count=1, wr_count=1.
REQ-027 Write 0xAB00 with LB_N=1 over stored 0x1234 at addr 5 -> readback 0xAB34; read with UB_N=1 -> DQ[15:8]=Z, DQ[7:0]=0x34.
REQ-028 Read addr 7, change to addr 9 during WAIT -> no drive until READ_LAT cycles after the change, data = mem[9], rd_count +1 only.
REQ-029 In DRIVE, assert WE_N=0 -> DQ released the same cycle (dq_oe=0), write performed, state IDLE.
REQ-030 Addr 2048+3 with MEM_WORDS=2048 -> accesses word 3; write 0xBEEF there, read addr 3 -> 0xBEEF.
REQ-031 Assert rst mid-WAIT and mid-DRIVE -> dq_oe=0 and DQ=Z before the next edge; counters 0; array data retained on the next read.
